// File: rtl/ysyx_22041211_ifu.sv
// Instruction fetch unit: holds the PC, fetches over a valid/ready memory
// channel and hands each instruction plus its PC to the decoder.
module ysyx_22041211_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ifu_arvalid_o,
    output logic [31:0] ifu_araddr_o,
    input  logic        ifu_arready_i,
    input  logic        ifu_rvalid_i,
    input  logic [31:0] ifu_rdata_i,
    input  logic [1:0]  ifu_rresp_i,
    output logic        ifu_rready_o,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        fetch_err_o,
    output logic [31:0] fetch_cnt_o
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_OUT
    } state_t;

    state_t            state, state_n;
    logic [XLEN-1:0]   pc, pc_n;
    logic              drop, drop_n;
    logic [XLEN-1:0]   araddr_n;
    logic [XLEN-1:0]   inst_n;
    logic [XLEN-1:0]   pc_out_n;
    logic              err_n;
    logic [XLEN-1:0]   cnt_n;

    // State, PC and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            pc            <= RESET_PC;
            drop          <= 1'b0;
            ifu_araddr_o  <= RESET_PC;
            ifu_arvalid_o <= 1'b0;
            ifu_rready_o  <= 1'b0;
            inst_valid_o  <= 1'b0;
            inst_o        <= '0;
            pc_o          <= '0;
            fetch_err_o   <= 1'b0;
            fetch_cnt_o   <= '0;
        end else begin
            state         <= state_n;
            pc            <= pc_n;
            drop          <= drop_n;
            ifu_araddr_o  <= araddr_n;
            ifu_arvalid_o <= (state_n == S_REQ);
            ifu_rready_o  <= (state_n == S_WAIT);
            inst_valid_o  <= (state_n == S_OUT);
            inst_o        <= inst_n;
            pc_o          <= pc_out_n;
            fetch_err_o   <= err_n;
            fetch_cnt_o   <= cnt_n;
        end
    end

    // Next-state, PC update, stale-response tracking and output latching
    always_comb begin
        state_n  = state;
        pc_n     = pc;
        drop_n   = drop;
        araddr_n = ifu_araddr_o;
        inst_n   = inst_o;
        pc_out_n = pc_o;
        err_n    = fetch_err_o;
        cnt_n    = fetch_cnt_o;

        case (state)
            S_IDLE: begin
                state_n = S_REQ;
            end
            S_REQ: begin
                if (ifu_arvalid_o && ifu_arready_i) begin
                    state_n = S_WAIT;
                end
                // The request in flight carries the old address; mark it stale
                if (redirect_i) begin
                    drop_n = 1'b1;
                end
            end
            S_WAIT: begin
                if (ifu_rvalid_i) begin
                    if (drop || redirect_i) begin
                        drop_n  = 1'b0;
                        state_n = S_REQ;
                    end else begin
                        inst_n   = (ifu_rresp_i != 2'b00) ? NOP_INST : ifu_rdata_i;
                        err_n    = fetch_err_o | (ifu_rresp_i != 2'b00);
                        pc_out_n = pc;
                        state_n  = S_OUT;
                    end
                end else if (redirect_i) begin
                    drop_n = 1'b1;
                end
            end
            S_OUT: begin
                if (inst_valid_o && inst_ready_i) begin
                    cnt_n   = fetch_cnt_o + XLEN'(1);
                    pc_n    = pc + XLEN'(4);
                    state_n = S_REQ;
                end
                if (redirect_i) begin
                    state_n = S_REQ;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Redirect target wins over sequential advance; force word alignment
        if (redirect_i) begin
            pc_n = {redirect_pc_i[31:2], 2'b00};
        end

        // A fresh request samples the PC; the address is then held until accepted
        if ((state_n == S_REQ) && (state != S_REQ)) begin
            araddr_n = pc_n;
        end
    end

endmodule

// File: doc/ysyx_22041211_ifu.md
Name: ysyx_22041211_ifu

Overview:
Instruction fetch unit. It is the producer end of the decoder's instruction interface: it holds the PC, issues read requests to instruction memory over a valid/ready request/response channel, and presents the fetched instruction with its PC to the decoder through a valid/ready handshake. It accepts redirects (branch target address from execute) and discards any in-flight stale fetch.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset.
NOP_INST, 32'h0000_0013, instruction word delivered when a fetch returns an error response.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
ifu_arvalid_o  output  1  read-request valid.
ifu_araddr_o  output  32  read-request address; equals the current PC.
ifu_arready_i  input  1  memory accepts the request.
ifu_rvalid_i  input  1  read-response valid.
ifu_rdata_i  input  32  instruction word.
ifu_rresp_i  input  2  response status; 2'b00 = OK, any other value = error.
ifu_rready_o  output  1  IFU accepts the response.
inst_valid_o  output  1  inst_o/pc_o valid toward the decoder.
inst_ready_i  input  1  decoder consumes the instruction.
inst_o  output  32  instruction to the decoder's inst_i.
pc_o  output  32  PC of inst_o, feeding the decoder's pc_i.
redirect_i  input  1  one-cycle redirect pulse (taken branch or jump).
redirect_pc_i  input  32  redirect target.
fetch_err_o  output  1  sticky error flag; cleared only by reset.
fetch_cnt_o  output  32  count of instructions delivered (inst handshakes).

Behaviour:
- Reset values (asynchronous, all outputs):
  - pc = RESET_PC, state = S_IDLE, drop = 0.
  - ifu_arvalid_o = 0, ifu_rready_o = 0, inst_valid_o = 0.
  - inst_o = 0, pc_o = 0, fetch_err_o = 0, fetch_cnt_o = 0.
- States: S_IDLE, S_REQ, S_WAIT, S_OUT.
- S_IDLE: no outputs asserted; moves to S_REQ on the next edge. It occurs only once, after reset release.
- S_REQ:
  - ifu_arvalid_o = 1 and ifu_araddr_o = pc.
  - The address stays stable while ifu_arvalid_o = 1 and arready is low.
  - On ifu_arvalid_o & ifu_arready_i, go to S_WAIT.
- S_WAIT:
  - ifu_rready_o = 1.
  - On ifu_rvalid_i with drop = 0: latch inst_o = rdata (or NOP_INST if rresp != 0, which also sets fetch_err_o), latch pc_o = pc, go to S_OUT.
  - On ifu_rvalid_i with drop = 1: discard the response, clear drop, go to S_REQ.
- S_OUT:
  - inst_valid_o = 1; inst_o and pc_o are held stable until the handshake.
  - On inst_valid_o & inst_ready_i: pc <= pc + 4 (32-bit wrap, 32'hFFFF_FFFC + 4 = 0), fetch_cnt_o += 1 (wraps), go to S_REQ.
- Minimum latency: request accepted at cycle N, response at N+1, inst_valid_o high at N+2.
- Redirect (redirect_i = 1), taking priority over pc + 4:
  - pc <= {redirect_pc_i[31:2], 2'b00}; the low bits are forced to zero.
  - In S_REQ before acceptance: the pending request completes with the old address, drop is set, the state follows normal S_REQ rules.
  - In S_REQ at the accept cycle: same as above (drop = 1, go to S_WAIT).
  - In S_WAIT: drop = 1. If rvalid arrives in the same cycle, that response is discarded directly and the block goes to S_REQ with drop left 0.
  - In S_OUT: inst_valid_o drops next cycle and the block goes to S_REQ.
  - In S_OUT coinciding with inst_ready_i: the handshake counts (fetch_cnt_o += 1), but pc takes the redirect target, not pc + 4.
  - In S_IDLE: pc is loaded with the target.
  - Back-to-back redirects: the last one wins; drop is a single flag because at most one request is outstanding.
- At most one outstanding request. ifu_arvalid_o and ifu_rready_o are never asserted in the same cycle.
- An ifu_rvalid_i pulse outside S_WAIT is ignored.
- fetch_err_o stays set until rst.
- Reset mid-operation returns immediately to reset values. A response arriving after reset in S_IDLE/S_REQ is ignored.

Test Plan:
- Reset release, memory arready = 1 always, rvalid one cycle after accept, inst_ready_i = 1 → addresses 0x80000000, 0x80000004, 0x80000008. inst_valid_o is first high 3 cycles after reset deassert. fetch_cnt_o = 3 after three handshakes.
- Decoder stalls (inst_ready_i = 0 for 5 cycles) with rdata = 0x00500093 → inst_o = 0x00500093 and pc_o = 0x80000000 held stable; no new ifu_arvalid_o until the handshake; the next address is 0x80000004.
- redirect_i with redirect_pc_i = 0x80000102 while in S_WAIT, response rdata = 0xDEADBEEF → response discarded, never valid to the decoder. The next request address is 0x80000100.
- Redirect in the same cycle as an S_OUT handshake, target 0x80000200 → fetch_cnt_o increments; next ifu_araddr_o = 0x80000200, not pc + 4.
- Response with ifu_rresp_i = 2'b10 → inst_o = 0x00000013, fetch_err_o = 1 and remains set through later good fetches until rst.
- rst asserted asynchronously mid-S_WAIT → all outputs reset without waiting for a clock edge. After release the first request is 0x80000000, and a stale rvalid arriving in S_IDLE is ignored.
